// File: rtl/crypt_pkg.sv
// Shared types and memory-map constants for the LFSR stream-encryption engine.
package crypt_pkg;

  typedef enum logic [2:0] {IDLE, P0, P1, P2, RUN, DONE} state_t;

  localparam logic [7:0] MSG_BASE  = 8'd0;
  localparam logic [7:0] PRE_ADDR  = 8'd41;
  localparam logic [7:0] TAP_ADDR  = 8'd42;
  localparam logic [7:0] INIT_ADDR = 8'd43;
  localparam logic [7:0] OUT_BASE  = 8'd64;
  localparam int         MSG_LEN   = 41;
  localparam int         OUT_LEN   = 64;
  localparam logic [7:0] SPACE     = 8'h20;

  // One LFSR step: shift left, feedback is the parity of the tapped bits.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s, input logic [7:0] t);
    return {s[6:0], ^(s & t)};
  endfunction

endpackage

// File: rtl/top_module_crypt_data_mem.sv
// 256-byte data memory: combinational read port, synchronous write port, never reset.
module data_mem
  import crypt_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] raddr,
  output logic [7:0] rdata,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata
);

  logic [7:0] my_memory [0:255];

  assign rdata = my_memory[raddr];

  always_ff @(posedge clk) begin
    if (we)
      my_memory[waddr] <= wdata;
  end

endmodule

// File: rtl/top_module_crypt.sv
// Encryption engine top: parameter fetch, 64-byte RUN loop with LFSR keystream, done flag.
module top_module_crypt
  import crypt_pkg::*;
(
  input  logic        clk,
  input  logic        start_n,
  input  logic [15:0] startAddress,
  output logic        halt
);

  state_t     state, state_nxt;
  logic [5:0] idx;
  logic [7:0] lfsr, pre, taps;
  logic [7:0] raddr, rdata, waddr, wdata;
  logic       we;
  logic [8:0] offset;
  logic       in_msg;

  data_mem DataMem (
    .clk   (clk),
    .raddr (raddr),
    .rdata (rdata),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata)
  );

  // Message index for this output slot; out-of-window slots become padding.
  assign offset = {3'b000, idx} - {1'b0, pre};
  assign in_msg = ({1'b0, pre} <= {3'b000, idx}) && (offset < 9'(MSG_LEN));

  always_comb begin
    state_nxt = state;
    raddr     = MSG_BASE;
    we        = 1'b0;
    waddr     = OUT_BASE + {2'b00, idx};
    wdata     = (in_msg ? rdata : SPACE) ^ lfsr;
    case (state)
      IDLE: state_nxt = (startAddress == 16'd0) ? P0 : DONE;
      P0: begin
        raddr     = PRE_ADDR;
        state_nxt = P1;
      end
      P1: begin
        raddr     = TAP_ADDR;
        state_nxt = P2;
      end
      P2: begin
        raddr     = INIT_ADDR;
        state_nxt = RUN;
      end
      RUN: begin
        raddr = MSG_BASE + offset[7:0];
        we    = 1'b1;
        if (idx == 6'(OUT_LEN - 1))
          state_nxt = DONE;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      state <= IDLE;
      idx   <= 6'd0;
      lfsr  <= 8'd0;
      pre   <= 8'd0;
      taps  <= 8'd0;
    end else begin
      state <= state_nxt;
      case (state)
        P0: pre  <= rdata;
        P1: taps <= rdata;
        P2: lfsr <= rdata;
        RUN: begin
          lfsr <= lfsr_next(lfsr, taps);
          idx  <= idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign halt = (state == DONE);

endmodule

// File: tb/tb_top_module_crypt.sv
// Directed self-checking bench for top_module_crypt using backdoor memory access.
module tb_top_module_crypt;

  logic        clk = 1'b0;
  logic        start_n = 1'b0;
  logic [15:0] startAddress = 16'd0;
  logic        halt;

  int          testsRun = 0;
  int          testsFailed = 0;
  int          haltCycles;
  string       msg = "Mr. Watson, come here. I want to see you.";
  logic [7:0]  expCt [0:63];
  logic [7:0]  snap  [0:127];

  top_module_crypt dut (
    .clk          (clk),
    .start_n      (start_n),
    .startAddress (startAddress),
    .halt         (halt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference keystream model: padded plaintext XOR LFSR, LFSR starting at init.
  task automatic buildExpected(input logic [7:0] pre, input logic [7:0] taps, input logic [7:0] init);
    logic [7:0] l;
    logic [7:0] p;
    int         j;
    l = init;
    for (int i = 0; i < 64; i++) begin
      j = i - int'(pre);
      p = (j >= 0 && j < 41) ? msg[j] : 8'h20;
      expCt[i] = p ^ l;
      l = {l[6:0], ^(l & taps)};
    end
  endtask

  task automatic loadMemory(input logic [7:0] pre, input logic [7:0] taps, input logic [7:0] init);
    for (int k = 0; k < 41; k++) dut.DataMem.my_memory[k] = msg[k];
    dut.DataMem.my_memory[41] = pre;
    dut.DataMem.my_memory[42] = taps;
    dut.DataMem.my_memory[43] = init;
    for (int k = 44; k < 64; k++)  dut.DataMem.my_memory[k] = 8'h5A;
    for (int k = 64; k < 128; k++) dut.DataMem.my_memory[k] = 8'hEE;
  endtask

  task automatic waitHalt(input int budget);
    haltCycles = 0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      if (halt) begin
        haltCycles = c;
        break;
      end
    end
    checkOutput("halt_raised", halt, 1);
  endtask

  task automatic applyStimulus(input logic [7:0] pre, input logic [7:0] taps, input logic [7:0] init,
                               input logic [15:0] sa, input int budget);
    @(negedge clk);
    start_n = 1'b0;
    startAddress = sa;
    loadMemory(pre, taps, init);
    @(negedge clk);
    checkOutput("halt_in_reset", halt, 0);
    start_n = 1'b1;
    waitHalt(budget);
  endtask

  task automatic checkCipher(input string tag);
    for (int i = 0; i < 64; i++)
      checkOutput($sformatf("%s_ct%0d", tag, i), dut.DataMem.my_memory[64+i], expCt[i]);
  endtask

  task automatic checkPreserved(input string tag, input logic [7:0] pre, input logic [7:0] taps,
                                input logic [7:0] init);
    for (int k = 0; k < 41; k++)
      checkOutput($sformatf("%s_msg%0d", tag, k), dut.DataMem.my_memory[k], msg[k]);
    checkOutput({tag, "_pre"},  dut.DataMem.my_memory[41], pre);
    checkOutput({tag, "_taps"}, dut.DataMem.my_memory[42], taps);
    checkOutput({tag, "_init"}, dut.DataMem.my_memory[43], init);
    for (int k = 44; k < 64; k++)
      checkOutput($sformatf("%s_gap%0d", tag, k), dut.DataMem.my_memory[k], 8'h5A);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_halt", halt, 0);

    // First ciphertext bytes against hand-computed values and the full model.
    buildExpected(8'd9, 8'hD4, 8'h40);
    applyStimulus(8'd9, 8'hD4, 8'h40, 16'd0, 200);
    checkOutput("t1_latency_ok", (haltCycles >= 6 && haltCycles <= 72), 1);
    checkOutput("t1_ct0", dut.DataMem.my_memory[64], 8'h60);
    checkOutput("t1_ct1", dut.DataMem.my_memory[65], 8'hA1);
    checkOutput("t1_ct2", dut.DataMem.my_memory[66], 8'h23);
    checkCipher("t1");
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t1_halt_held", halt, 1);
    checkPreserved("t1", 8'd9, 8'hD4, 8'h40);

    // Zero LFSR: ciphertext is the padded plaintext.
    applyStimulus(8'd9, 8'hD4, 8'h00, 16'd0, 200);
    for (int i = 64; i < 73; i++)
      checkOutput($sformatf("t2_pad%0d", i), dut.DataMem.my_memory[i], 8'h20);
    checkOutput("t2_first_M", dut.DataMem.my_memory[73], 8'h4D);
    for (int k = 0; k < 41; k++)
      checkOutput($sformatf("t2_msg%0d", k), dut.DataMem.my_memory[73+k], msg[k]);
    for (int i = 114; i < 128; i++)
      checkOutput($sformatf("t2_tail%0d", i), dut.DataMem.my_memory[i], 8'h20);

    // Truncation: large preamble pushes message tail past slot 63.
    buildExpected(8'd30, 8'hD4, 8'h40);
    applyStimulus(8'd30, 8'hD4, 8'h40, 16'd0, 200);
    checkCipher("t3");

    // Non-encrypt select: quick completion, output area untouched.
    applyStimulus(8'd9, 8'hD4, 8'h40, 16'd1, 2);
    for (int i = 64; i < 128; i++)
      checkOutput($sformatf("t4_untouched%0d", i), dut.DataMem.my_memory[i], 8'hEE);

    // Reset mid-run, then a clean rerun with different parameters.
    @(negedge clk);
    start_n = 1'b0;
    startAddress = 16'd0;
    loadMemory(8'd9, 8'hD4, 8'h40);
    @(negedge clk);
    start_n = 1'b1;
    repeat (20) @(posedge clk);
    #3;
    start_n = 1'b0;
    #1;
    checkOutput("t5_abort_halt", halt, 0);
    for (int i = 64; i < 128; i++) snap[i] = dut.DataMem.my_memory[i];
    repeat (5) @(negedge clk);
    for (int i = 64; i < 128; i++)
      checkOutput($sformatf("t5_frozen%0d", i), dut.DataMem.my_memory[i], snap[i]);
    checkOutput("t5_unreached_127", dut.DataMem.my_memory[127], 8'hEE);
    checkOutput("t5_halt_low", halt, 0);

    buildExpected(8'd11, 8'hB4, 8'h40);
    applyStimulus(8'd11, 8'hB4, 8'h40, 16'd0, 200);
    checkCipher("t5");
    checkPreserved("t5", 8'd11, 8'hB4, 8'h40);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
